// File: rtl/mips_cpu_regs.sv
// mips_cpu_regs: 32 x 32-bit MIPS register file, r0 hardwired to zero.
// Two combinational read ports, one synchronous write port, $v0 mirror.
//
// Ports:
//   clk          write clock (rising edge)
//   reset        asynchronous active-high clear of all registers
//   read_reg_1/2 read indices; read_data_1/2 return contents same cycle
//   write_reg    write index; write_data written when write_en is high
//   register_v0  continuous view of register V0_INDEX ($v0)
//
// Option: define REGS_BYPASS_EN for write-first forwarding to the
// read ports and register_v0.
module mips_cpu_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int V0_INDEX   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic [DATA_WIDTH-1:0] register_v0
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] V0_ADDR = ADDR_WIDTH'(V0_INDEX);

  logic [DATA_WIDTH-1:0] regs [NREGS];

  // r0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

`ifdef REGS_BYPASS_EN
  logic wr_hit;

  always_comb begin
    wr_hit = write_en && !reset && (write_reg != '0);
    read_data_1 = regs[read_reg_1];
    read_data_2 = regs[read_reg_2];
    register_v0 = regs[V0_ADDR];
    if (wr_hit && (write_reg == read_reg_1)) begin
      read_data_1 = write_data;
    end
    if (wr_hit && (write_reg == read_reg_2)) begin
      read_data_2 = write_data;
    end
    if (wr_hit && (write_reg == V0_ADDR)) begin
      register_v0 = write_data;
    end
  end
`else
  always_comb begin
    read_data_1 = regs[read_reg_1];
    read_data_2 = regs[read_reg_2];
    register_v0 = regs[V0_ADDR];
  end
`endif

endmodule

// File: tb/tb_mips_cpu_regs.sv
// tb_mips_cpu_regs: directed vectors for the MIPS register file.
// Table of write/read records plus hand sequences for reset and same-cycle reads.
module tb_mips_cpu_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] register_v0;

  int checks = 0;
  int errors = 0;

  mips_cpu_regs dut (
    .clk         (clk),
    .reset       (reset),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .write_en    (write_en),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .register_v0 (register_v0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] expv0;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd2,  32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'h00008000, 5'd5,  5'd6,  32'h00008000, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 5'd6,  32'h000a0000, 5'd5,  5'd6,  32'h00008000, 32'h000a0000, 32'h0};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'h00008000, 32'h0};
    vecs[4] = '{1'b1, 5'd2,  32'h12345678, 5'd2,  5'd0,  32'h12345678, 32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd2,  32'h00008000, 32'h12345678, 32'h12345678};
    vecs[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678};
    vecs[7] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd6,  32'h00000001, 32'h000a0000, 32'h12345678};
    vecs[8] = '{1'b1, 5'd2,  32'h0,        5'd2,  5'd1,  32'h0,        32'h00000001, 32'h0};

    reset = 1'b1;
    write_en = 1'b1;
    write_reg = 5'd3;
    write_data = 32'h33333333;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd2;
    #1;
    chk("rst_rd1", read_data_1, 32'h0);
    chk("rst_rd2", read_data_2, 32'h0);
    chk("rst_v0", register_v0, 32'h0);
    @(posedge clk);
    #1;
    read_reg_1 = 5'd3;
    #1;
    chk("rst_write_ignored", read_data_1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    write_en = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      write_en = vecs[i].we;
      write_reg = vecs[i].wreg;
      write_data = vecs[i].wdata;
      read_reg_1 = vecs[i].r1;
      read_reg_2 = vecs[i].r2;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd1", i), read_data_1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), read_data_2, vecs[i].exp2);
      chk($sformatf("vec%0d_v0", i), register_v0, vecs[i].expv0);
    end

    // Read index change is visible without a clock edge.
    @(negedge clk);
    write_en = 1'b0;
    read_reg_1 = 5'd31;
    #1;
    chk("comb_read_idx", read_data_1, 32'hA5A5A5A5);

    // Same-cycle write and read of r7: old value until the edge.
    @(negedge clk);
    write_en = 1'b1;
    write_reg = 5'd7;
    write_data = 32'hDEADBEEF;
    read_reg_1 = 5'd7;
    read_reg_2 = 5'd7;
    #1;
`ifdef REGS_BYPASS_EN
    chk("same_cycle_r7", read_data_1, 32'hDEADBEEF);
`else
    chk("same_cycle_r7", read_data_1, 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("after_edge_r7", read_data_2, 32'hDEADBEEF);

    // Same-cycle write to $v0.
    @(negedge clk);
    write_reg = 5'd2;
    write_data = 32'hCAFEF00D;
    #1;
`ifdef REGS_BYPASS_EN
    chk("same_cycle_v0", register_v0, 32'hCAFEF00D);
`else
    chk("same_cycle_v0", register_v0, 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("after_edge_v0", register_v0, 32'hCAFEF00D);

    // Reset between edges clears immediately and beats a pending write.
    @(negedge clk);
    write_en = 1'b0;
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd6;
    #1;
    chk("pre_rst_r5", read_data_1, 32'h00008000);
    #1;
    reset = 1'b1;
    write_en = 1'b1;
    write_reg = 5'd5;
    write_data = 32'h55555555;
    #1;
    chk("async_rst_r5", read_data_1, 32'h0);
    chk("async_rst_r6", read_data_2, 32'h0);
    chk("async_rst_v0", register_v0, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_beats_write", read_data_1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_r6", read_data_2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
